sr_debounce_ctrl: RTL and testbench

//  Front-end stage for the SR latch: conditions raw, asynchronous set/reset switch inputs into clean S/R drive.

---
 rtl/sr_debounce_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sr_debounce_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sr_debounce_ctrl.sv
// sr_debounce_ctrl: conditions raw, bouncing set/reset switch inputs into
// clean, mutually exclusive one-cycle S/R pulses. It also keeps a registered
// q/qbar pair that mirrors the downstream SR latch state.
module sr_debounce_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_PRIORITY  = 1,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic s_raw,
  input  logic r_raw,
  output logic s_pulse,
  output logic r_pulse,
  output logic q,
  output logic qbar,
  output logic conflict
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK_HI = 2'd1,
    HELD     = 2'd2,
    CHECK_LO = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Channel 0 is set, channel 1 is reset.
  logic [1:0] raw;
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] qual;

  assign raw = {r_raw, s_raw};

  // Two-flop synchroniser per channel; only sync2 is seen by the FSMs.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  // Synchroniser registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, no matter how the blocks are ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_sync;
    logic             qual_ch;

    assign x_sync = sync2_q[ch];

    // Debounce state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next-state logic: a level must persist DEBOUNCE_CYCLES counted cycles
    // before the channel is considered pressed or released.
    always_comb begin
      // NOTE: defaults first so that every path assigns every output, which
      // prevents latch inference.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        IDLE: begin
          if (x_sync) begin
            state_d = CHECK_HI;
            cnt_d   = CNT_W'(1);
          end
        end
        CHECK_HI: begin
          if (!x_sync) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_TGT) begin
            state_d = HELD;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!x_sync) begin
            state_d = CHECK_LO;
            cnt_d   = CNT_W'(1);
          end
        end
        CHECK_LO: begin
          if (x_sync) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_TGT) begin
            state_d = IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Output logic: qualify on the single cycle that CHECK_HI commits to HELD.
    always_comb begin
      qual_ch = (state_q == CHECK_HI) && x_sync && (cnt_q == CNT_TGT);
    end

    assign qual[ch] = qual_ch;
  end

  logic s_pulse_q, s_pulse_d;
  logic r_pulse_q, r_pulse_d;
  logic conflict_q, conflict_d;
  logic q_q, q_d;

  // Arbitration: a same-cycle double qualify keeps only the priority pulse.
  // The loser's FSM still goes to HELD, so that press is consumed.
  always_comb begin
    s_pulse_d  = qual[0];
    r_pulse_d  = qual[1];
    conflict_d = 1'b0;
    if (qual[0] && qual[1]) begin
      conflict_d = 1'b1;
      if (RESET_PRIORITY != 0) s_pulse_d = 1'b0;
      else                     r_pulse_d = 1'b0;
    end
  end

  // Latch mirror: the registered pulses are never both high.
  always_comb begin
    q_d = q_q;
    if (s_pulse_q)      q_d = 1'b1;
    else if (r_pulse_q) q_d = 1'b0;
  end

  // Pulse, conflict and latch-state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_pulse_q  <= 1'b0;
      r_pulse_q  <= 1'b0;
      conflict_q <= 1'b0;
      q_q        <= 1'b0;
    end else begin
      s_pulse_q  <= s_pulse_d;
      r_pulse_q  <= r_pulse_d;
      conflict_q <= conflict_d;
      q_q        <= q_d;
    end
  end

  assign s_pulse  = s_pulse_q;
  assign r_pulse  = r_pulse_q;
  assign conflict = conflict_q;
  assign q        = q_q;
  assign qbar     = ~q_q;

endmodule

// File: tb/tb_sr_debounce_ctrl.sv
// Testbench for sr_debounce_ctrl with default parameters (DEBOUNCE_CYCLES=4,
// RESET_PRIORITY=1). A table of per-cycle vectors covers the main flows.
// Reset behaviour is covered by hand-written sequences.
module tb_sr_debounce_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic s_raw;
  logic r_raw;
  logic s_pulse;
  logic r_pulse;
  logic q;
  logic qbar;
  logic conflict;

  sr_debounce_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .s_raw    (s_raw),
    .r_raw    (r_raw),
    .s_pulse  (s_pulse),
    .r_pulse  (r_pulse),
    .q        (q),
    .qbar     (qbar),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s;
    logic r;
    logic sp;
    logic rp;
    logic cf;
    logic q;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic sp, input logic rp,
                            input logic cf, input logic eq);
    check({tag, " s_pulse"},  s_pulse,  sp);
    check({tag, " r_pulse"},  r_pulse,  rp);
    check({tag, " conflict"}, conflict, cf);
    check({tag, " q"},        q,        eq);
    check({tag, " qbar"},     qbar,     ~eq);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic s, input logic r, input logic sp,
                      input logic rp, input logic cf, input logic eq);
    vec_t v;
    v.s  = s;
    v.r  = r;
    v.sp = sp;
    v.rp = rp;
    v.cf = cf;
    v.q  = eq;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic s, input logic r, input logic eq);
    repeat (n) addv(s, r, 1'b0, 1'b0, 1'b0, eq);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Each vector is applied just after an edge and checked just after the
    // next edge. Offset 0 is the first edge that samples the new input.

    // Clean set from q=0: pulse at offset 6, q=1 from offset 7.
    add_n(6, 1, 0, 0);
    addv (1, 0, 1, 0, 0, 0);
    add_n(3, 1, 0, 1);
    add_n(8, 0, 0, 1);
    // Simultaneous press from q=1: reset wins, conflict flagged, q falls.
    add_n(6, 1, 1, 1);
    addv (1, 1, 0, 1, 1, 1);
    add_n(3, 1, 1, 0);
    add_n(8, 0, 0, 0);
    // Bounce: 3 high, 1 low, then high; pulse 6 edges after last rise.
    add_n(3, 1, 0, 0);
    add_n(1, 0, 0, 0);
    add_n(6, 1, 0, 0);
    addv (1, 0, 1, 0, 0, 0);
    add_n(3, 1, 0, 1);
    add_n(8, 0, 0, 1);
    // s held (pulse at 6) while r presses at offset 3 (pulse at 9), q -> 0.
    add_n(3, 1, 0, 1);
    add_n(3, 1, 1, 1);
    addv (1, 1, 1, 0, 0, 1);
    add_n(2, 1, 1, 1);
    addv (1, 1, 0, 1, 0, 1);
    add_n(3, 1, 1, 0);
    add_n(8, 0, 0, 0);

    // Reset asserted with both raw inputs high: outputs must stay idle.
    rst   = 1'b1;
    s_raw = 1'b1;
    r_raw = 1'b1;
    #1;
    check_outs("reset_async", 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_outs($sformatf("reset_hold%0d", k), 0, 0, 0, 0);
    end
    s_raw = 1'b0;
    r_raw = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Table-driven main flows.
    foreach (vecs[i]) begin
      s_raw = vecs[i].s;
      r_raw = vecs[i].r;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].sp, vecs[i].rp, vecs[i].cf, vecs[i].q);
    end

    // Reset mid-count: s pressed, rst at edge 4, s kept high throughout.
    s_raw = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      check_outs($sformatf("midrst_pre%0d", k), 0, 0, 0, 0);
    end
    #2;
    rst = 1'b1;
    #1;
    check_outs("midrst_assert", 0, 0, 0, 0);
    tick();
    check_outs("midrst_held", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      check_outs($sformatf("midrst_post%0d", k), (k == 6), 0, 0, (k >= 7));
    end

    // Asynchronous reset while q=1 must clear q immediately.
    #2;
    rst = 1'b1;
    #1;
    check("rst_clears_q q", q, 1'b0);
    check("rst_clears_q qbar", qbar, 1'b1);
    s_raw = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
